dmem_responder: RTL and testbench

// Data-memory responder answering MEM-stage load/store requests with configurable wait states.

---
 rtl/dmem_responder.sv | 102 ++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory responder with programmable wait states
// Latches one load/store, stalls the pipeline for LATENCY cycles, then acks with data or err.
module dmem_responder #(
    parameter int SIZE    = 1024,
    parameter int LATENCY = 2,
    parameter int WORD    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_read,
    input  logic            req_write,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] write_data,
    output logic            stall,
    output logic            ack,
    output logic [WORD-1:0] read_data,
    output logic            err
);
    localparam int AW = $clog2(SIZE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_rd;
    logic            r_wr;
    logic [WORD-1:0] r_addr;
    logic [WORD-1:0] r_wdata;
    logic [WORD-1:0] r_mem [SIZE];
    logic            r_ack;
    logic            r_err;
    logic [WORD-1:0] r_rdata;

    logic            w_req;
    logic            w_bad;
    logic [AW-1:0]   w_idx;

    assign w_req = req_read | req_write;
    // Any address bit above the word index means the access is beyond the RAM; it never wraps.
    assign w_bad = (r_addr[1:0] != 2'b00) || (r_addr[WORD-1:AW+2] != '0) || (r_rd && r_wr);
    assign w_idx = r_addr[AW+1:2];

    assign stall     = ((r_state == IDLE) && w_req) || (r_state == BUSY);
    assign ack       = r_ack;
    assign err       = r_err;
    assign read_data = r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            for (int i = 0; i < SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_rd    <= req_read;
                        r_wr    <= req_write;
                        r_addr  <= address;
                        r_wdata <= write_data;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= DONE;
                        if (w_bad) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else if (r_wr) begin
                            r_mem[w_idx] <= r_wdata;
                        end else begin
                            r_rdata <= r_mem[w_idx];
                        end
                    end
                end
                DONE: begin
                    // Single-cycle completion; the next request is only looked at from IDLE.
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (LATENCY=2 and LATENCY=1)
module tb_dmem_responder;
    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        req_read, req_write;
    logic [31:0] address, write_data;
    logic        stall, ack, err;
    logic [31:0] read_data;

    logic        b_req_read, b_req_write;
    logic [31:0] b_address, b_write_data;
    logic        b_stall, b_ack, b_err;
    logic [31:0] b_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] model_rd;

    dmem_responder #(.SIZE(1024), .LATENCY(LAT), .WORD(32)) u_dut (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
        .address(address), .write_data(write_data), .stall(stall), .ack(ack),
        .read_data(read_data), .err(err)
    );

    dmem_responder #(.SIZE(1024), .LATENCY(1), .WORD(32)) u_dut_l1 (
        .clk(clk), .reset(reset), .req_read(b_req_read), .req_write(b_req_write),
        .address(b_address), .write_data(b_write_data), .stall(b_stall), .ack(b_ack),
        .read_data(b_read_data), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with empty scoreboard expected none");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("ack_err", {31'b0, err}, {31'b0, e.err});
                chk("ack_read_data", read_data, e.rdata);
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input bit sw, input logic [31:0] addr2);
        exp_t e;
        int   idx;
        int   cyc;
        bit   got;
        idx   = int'(addr[11:2]);
        e.err = (addr[1:0] != 2'b00) || (addr >= 32'h1000) || (rd && wr);
        if (e.err) begin
            model_rd = 32'h0;
        end else if (wr) begin
            model_mem[idx] = wd;
        end else begin
            model_rd = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        end
        e.rdata = model_rd;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        req_read = rd; req_write = wr; address = addr; write_data = wd;
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1;
                chk("ack_cycle", cyc, LAT + 1);
                chk("stall_in_done", {31'b0, stall}, 32'h0);
            end else begin
                chk("stall_busy", {31'b0, stall}, 32'h1);
            end
            if (sw && cyc == 1) address = addr2;
            cyc++;
        end
        req_read = 1'b0; req_write = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack in 20 cycles expected ack in cycle %0d", LAT + 1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        @(negedge clk);
        chk("ack_one_cycle", {31'b0, ack}, 32'h0);
        chk("idle_no_stall", {31'b0, stall}, 32'h0);
    endtask

    task automatic issue_b(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
        int cyc;
        bit got;
        @(posedge clk);
        #1;
        b_req_read = rd; b_req_write = wr; b_address = addr; b_write_data = wd;
        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (b_ack === 1'b1) begin
                got = 1;
                chk("l1_ack_cycle", cyc, 2);
                chk("l1_read_data", b_read_data, exp_rd);
                chk("l1_err", {31'b0, b_err}, 32'h0);
            end
            cyc++;
        end
        b_req_read = 1'b0; b_req_write = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL l1_ack_timeout: got no ack in 20 cycles expected ack in cycle 2");
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_read = 1'b0; req_write = 1'b0; address = '0; write_data = '0;
        b_req_read = 1'b0; b_req_write = 1'b0; b_address = '0; b_write_data = '0;
        model_rd = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_ack", {31'b0, ack}, 32'h0);
        chk("reset_err", {31'b0, err}, 32'h0);
        chk("reset_read_data", read_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);

        issue(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0);

        issue(1'b0, 1'b1, 32'h1000, 32'h1234, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        issue(1'b0, 1'b1, 32'h8, 32'h22222222, 1'b0, 32'h0);
        issue(1'b1, 1'b1, 32'h8, 32'h00009999, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0);

        issue(1'b0, 1'b1, 32'h4, 32'h11111111, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 32'h8);

        // Reset during BUSY of a store: the store must be lost and RAM cleared.
        @(posedge clk);
        #1;
        req_write = 1'b1; address = 32'h20; write_data = 32'h55;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_busy", {31'b0, stall}, 32'h1);
        req_write = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_reset_stall", {31'b0, stall}, 32'h0);
        chk("mid_reset_ack", {31'b0, ack}, 32'h0);
        chk("mid_reset_err", {31'b0, err}, 32'h0);
        chk("mid_reset_read_data", read_data, 32'h0);
        model_mem.delete();
        model_rd = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);

        issue_b(1'b0, 1'b1, 32'h0, 32'h0000A5A5, 32'h0);
        issue_b(1'b1, 1'b0, 32'h0, 32'h0, 32'h0000A5A5);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
